// File: rtl/accum_pkg.sv
// Shared definitions for the window accumulator: FSM state encoding,
// the legal range of the window-size parameter and the accumulator width helper.
package accum_pkg;

   // ACCUM collects samples; HOLD presents a finished window result.
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   // Window length is 2**WIN_LOG2 samples.
   localparam int WIN_LOG2_MIN = 1;
   localparam int WIN_LOG2_MAX = 6;

   // One carry bit above the adder result plus WIN_LOG2 growth bits,
   // so a full window of maximum samples can never overflow.
   function automatic int acc_width(input int data_w, input int win_log2);
      return data_w + 1 + win_log2;
   endfunction

endpackage

// File: rtl/sum_window_accum.sv
// Window accumulator behind the 8-bit operand adder. Sums 2**WIN_LOG2 samples
// of {carry, result}, then holds the total and truncated mean until accepted.
// Optional feature macro: ACCUM_PEAK_EN adds the out_peak port and peak tracking.
module sum_window_accum
   import accum_pkg::*;
#(
   parameter  int WIN_LOG2 = 3,
   parameter  int DATA_W   = 8,
   localparam int ACC_W    = acc_width(DATA_W, WIN_LOG2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_carry,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_total,
   output logic [DATA_W:0]   out_mean
`ifdef ACCUM_PEAK_EN
   ,
   output logic [DATA_W:0]   out_peak
`endif
);

   localparam int SMP_W = DATA_W + 1;

   if (WIN_LOG2 < WIN_LOG2_MIN || WIN_LOG2 > WIN_LOG2_MAX) begin : g_bad_win_log2
      $error("sum_window_accum: WIN_LOG2 must lie in 1..6");
   end

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [WIN_LOG2-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0]   total_q, total_d;
   logic [SMP_W-1:0]   mean_q, mean_d;

   logic [SMP_W-1:0]   sample;
   logic [ACC_W-1:0]   sum_w;
   logic               xfer;
   logic               last;

   assign sample = {in_carry, in_data};
   assign sum_w  = acc_q + ACC_W'(sample);
   // Transfers are only possible in ACCUM; in HOLD the input is back-pressured.
   assign xfer   = in_valid && (state_q == ACCUM);
   assign last   = (cnt_q == {WIN_LOG2{1'b1}});

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; clear overrides any pending handshake.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ACCUM;
      end else begin
         case (state_q)
            ACCUM:   if (xfer && last) state_d = HOLD;
            HOLD:    if (out_ready)    state_d = ACCUM;
            default: state_d = ACCUM;
         endcase
      end
   end

   // Handshake outputs decoded straight from the state register.
   always_comb begin
      in_ready  = (state_q == ACCUM);
      out_valid = (state_q == HOLD);
   end

   // Accumulator, sample counter and result registers.
   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      total_d = total_q;
      mean_d  = mean_q;
      if (clear) begin
         acc_d   = '0;
         cnt_d   = '0;
         total_d = '0;
         mean_d  = '0;
      end else if (xfer) begin
         if (last) begin
            total_d = sum_w;
            mean_d  = sum_w[ACC_W-1:WIN_LOG2];
            acc_d   = '0;
            cnt_d   = '0;
         end else begin
            acc_d = sum_w;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         total_q <= '0;
         mean_q  <= '0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
         mean_q  <= mean_d;
      end
   end

   assign out_total = total_q;
   assign out_mean  = mean_q;

`ifdef ACCUM_PEAK_EN
   logic [SMP_W-1:0] peak_q, peak_d;
   logic [SMP_W-1:0] out_peak_q, out_peak_d;
   logic [SMP_W-1:0] peak_max;

   assign peak_max = (sample > peak_q) ? sample : peak_q;

   // Running maximum; published and restarted when the window closes.
   always_comb begin
      peak_d     = peak_q;
      out_peak_d = out_peak_q;
      if (clear) begin
         peak_d     = '0;
         out_peak_d = '0;
      end else if (xfer) begin
         if (last) begin
            out_peak_d = peak_max;
            peak_d     = '0;
         end else begin
            peak_d = peak_max;
         end
      end
   end

   // Peak registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         peak_q     <= '0;
         out_peak_q <= '0;
      end else begin
         peak_q     <= peak_d;
         out_peak_q <= out_peak_d;
      end
   end

   assign out_peak = out_peak_q;
`else
   // Without peak tracking there is no peak register and no out_peak port.
`endif

endmodule

// File: tb/tb_sum_window_accum.sv
// Self-checking bench for sum_window_accum: a driver with a window-level
// reference model, and a monitor that scores each accepted result.
// Build with ACCUM_PEAK_EN defined to also check out_peak.
module tb_sum_window_accum;

   localparam int WIN_LOG2 = 3;
   localparam int DATA_W   = 8;
   localparam int ACC_W    = DATA_W + 1 + WIN_LOG2;
   localparam int N        = 1 << WIN_LOG2;

   logic              clk = 1'b0;
   logic              rst;
   logic              clear;
   logic [DATA_W-1:0] in_data;
   logic              in_carry;
   logic              in_valid;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_total;
   logic [DATA_W:0]   out_mean;
`ifdef ACCUM_PEAK_EN
   logic [DATA_W:0]   out_peak;
`endif

   sum_window_accum #(.WIN_LOG2(WIN_LOG2), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_data   (in_data),
      .in_carry  (in_carry),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_total (out_total),
      .out_mean  (out_mean)
`ifdef ACCUM_PEAK_EN
      ,
      .out_peak  (out_peak)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int total;
      int mean;
      int peak;
   } res_t;

   res_t exp_q[$];   // results awaiting acceptance
   int   win[$];     // samples of the window being collected
   bit   m_hold;     // model: a result is being presented
   int   e_total, e_mean, e_peak;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: scores every accepted result against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (mon_en && out_valid === 1'b1 && out_ready && !clear && !rst) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               res_t r;
               r = exp_q.pop_front();
               chk("sb_total", int'(out_total), r.total);
               chk("sb_mean", int'(out_mean), r.mean);
`ifdef ACCUM_PEAK_EN
               chk("sb_peak", int'(out_peak), r.peak);
`endif
               $display("result accepted: total=%0d mean=%0d (expected %0d/%0d)",
                        out_total, out_mean, r.total, r.mean);
            end
         end
      end
   end

   // One clock of stimulus: check DUT against the model, drive, advance model.
   task automatic cycle(input bit v, input int s, input bit ordy, input bit clr,
                        input bit rs, input bit do_chk, output bit accepted);
      logic [8:0] sv;
      @(negedge clk);
      if (do_chk) begin
         chk("in_ready", int'(in_ready), int'(!m_hold));
         chk("out_valid", int'(out_valid), int'(m_hold));
         chk("out_total", int'(out_total), e_total);
         chk("out_mean", int'(out_mean), e_mean);
`ifdef ACCUM_PEAK_EN
         chk("out_peak", int'(out_peak), e_peak);
`endif
      end
      sv = s[8:0];
      in_valid  = v;
      {in_carry, in_data} = sv;
      out_ready = ordy;
      clear     = clr;
      rst       = rs;
      accepted  = 1'b0;
      if (rs || clr) begin
         win.delete();
         exp_q.delete();
         m_hold  = 1'b0;
         e_total = 0;
         e_mean  = 0;
         e_peak  = 0;
      end else if (!m_hold && v) begin
         accepted = 1'b1;
         win.push_back(int'(sv));
         if (win.size() == N) begin
            res_t r;
            r.total = 0;
            r.peak  = 0;
            foreach (win[i]) begin
               r.total += win[i];
               if (win[i] > r.peak) r.peak = win[i];
            end
            r.mean  = r.total / N;
            e_total = r.total;
            e_mean  = r.mean;
            e_peak  = r.peak;
            exp_q.push_back(r);
            m_hold = 1'b1;
            win.delete();
         end
      end else if (m_hold && ordy) begin
         m_hold = 1'b0;
      end
   endtask

   // Present a sample until accepted, with a bounded wait.
   task automatic send(input int s);
      bit a;
      int n;
      n = 0;
      do begin
         cycle(1'b1, s, 1'b1, 1'b0, 1'b0, 1'b1, a);
         n++;
      end while (!a && n < 20);
      if (!a) chk("send_timeout", 0, 1);
   endtask

   task automatic idle(input int cycles, input bit ordy);
      bit a;
      for (int i = 0; i < cycles; i++) cycle(1'b0, 0, ordy, 1'b0, 1'b0, 1'b1, a);
   endtask

   initial begin
      bit a;
      int peak_pat[8];
      peak_pat = '{3, 200, 9, 0, 5, 7, 1, 2};

      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_carry = 1'b0;
      in_data = '0; out_ready = 1'b0;
      m_hold = 1'b0; e_total = 0; e_mean = 0; e_peak = 0;

      // Reset for two cycles, then check idle state.
      cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, a);
      cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, a);
      mon_en = 1'b1;
      idle(2, 1'b0);

      // Basic window: 8 x 10.
      for (int i = 0; i < N; i++) send(10);
      idle(2, 1'b1);

      // Maximum samples with carry: 8 x 511.
      for (int i = 0; i < N; i++) send(511);
      idle(2, 1'b1);

      // Peak pattern.
      for (int i = 0; i < N; i++) send(peak_pat[i]);
      idle(2, 1'b1);

      // Backpressure: result held 5 cycles while upstream keeps offering 99.
      for (int i = 0; i < N; i++) send(20);
      for (int i = 0; i < 5; i++) cycle(1'b1, 99, 1'b0, 1'b0, 1'b0, 1'b1, a);
      send(99);
      for (int i = 1; i < N; i++) send(1);
      idle(2, 1'b1);

      // Truncation: 1,1,1,1,1,1,1,2.
      for (int i = 0; i < N - 1; i++) send(1);
      send(2);
      idle(2, 1'b1);

      // Clear mid-window, then a fresh window of 4s.
      for (int i = 0; i < 5; i++) send(50);
      cycle(1'b1, 77, 1'b1, 1'b1, 1'b0, 1'b1, a);
      for (int i = 0; i < N; i++) send(4);
      idle(2, 1'b1);

      // Clear while holding a result.
      for (int i = 0; i < N; i++) send(30);
      cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, a);
      idle(3, 1'b0);

      // Randomized traffic with occasional clears.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 511)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 60) == 0,
               1'b0, 1'b1, a);
      end
      idle(4, 1'b1);
      chk("scoreboard_drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
